fg_prog_sequencer: RTL

- Digital sequencer for floating-gate programming of one analog island's TA2Cell array (e.g. a cascaded Mead SOS filter).
- Accepts a stream of (row, col, target) entries and drives the 6-bit VINJ row decoder and the drain-select/4T-gate column switches.
- Runs a measure-then-inject loop per device: measure, compare to target, apply a fixed-width injection pulse, repeat until the target is reached or the pulse budget is exhausted.
- Reports one result per entry.

---
 rtl/fg_prog_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer for one analog island's TA2Cell array.
// Takes (row, col, target) entries and runs a measure/inject loop per device until the target is reached or the budget is spent.
module fg_prog_sequencer #(
  parameter int ROW_W         = 6,
  parameter int COL_W         = 4,
  parameter int CODE_W        = 10,
  parameter int PCNT_W        = 8,
  parameter int PULSE_CYCLES  = 100,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_PULSES    = 255,
  parameter int MEAS_TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ent_valid,
  output logic              ent_ready,
  input  logic [ROW_W-1:0]  ent_row,
  input  logic [COL_W-1:0]  ent_col,
  input  logic [CODE_W-1:0] ent_target,
  input  logic              ent_last,
  input  logic              abort,
  output logic              meas_req,
  input  logic              meas_done,
  input  logic [CODE_W-1:0] meas_code,
  output logic              prog_mode,
  output logic [ROW_W-1:0]  row_addr,
  output logic [COL_W-1:0]  col_addr,
  output logic              drain_en,
  output logic              inj_pulse,
  output logic              res_valid,
  output logic              res_ok,
  output logic              res_timeout,
  output logic [PCNT_W-1:0] res_pulses,
  output logic              busy
);

  // One shared timer covers settle, pulse and measurement-timeout intervals.
  localparam int TMR_MAX_A = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_MAX   = (TMR_MAX_A > MEAS_TIMEOUT) ? TMR_MAX_A : MEAS_TIMEOUT;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  PULSE_LAST  = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  MEAS_LAST   = TMR_W'(MEAS_TIMEOUT - 1);
  localparam logic [PCNT_W-1:0] PCNT_BUDGET = PCNT_W'(MAX_PULSES);
  localparam logic [PCNT_W-1:0] PCNT_SAT    = '1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ENT,
    SETTLE,
    MEAS,
    INJECT,
    RESULT
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [TMR_W-1:0]   tmr;
  logic [PCNT_W-1:0]  pcnt;
  logic [CODE_W-1:0]  target;
  logic               last;
  logic               accept;
  logic               load_result;
  logic               result_ok;
  logic               result_timeout;

  // An abort in WAIT_ENT withdraws ready so a simultaneous offer is never taken.
  assign ent_ready = ~reset & ((state == IDLE) | ((state == WAIT_ENT) & ~abort));
  assign accept    = ent_valid & ent_ready;
  assign meas_req  = (state == MEAS);
  assign inj_pulse = (state == INJECT);
  assign busy      = (state != IDLE);
  assign res_valid = (state == RESULT) & ~abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n        = state;
    load_result    = 1'b0;
    result_ok      = 1'b0;
    result_timeout = 1'b0;
    case (state)
      IDLE, WAIT_ENT: if (accept) state_n = SETTLE;
      SETTLE:         if (tmr == SETTLE_LAST) state_n = MEAS;
      MEAS: begin
        if (meas_done) begin
          if (meas_code >= target) begin
            state_n     = RESULT;
            load_result = 1'b1;
            result_ok   = 1'b1;
          end else if (pcnt == PCNT_BUDGET) begin
            state_n     = RESULT;
            load_result = 1'b1;
          end else begin
            state_n = INJECT;
          end
        end else if (tmr == MEAS_LAST) begin
          state_n        = RESULT;
          load_result    = 1'b1;
          result_timeout = 1'b1;
        end
      end
      INJECT:  if (tmr == PULSE_LAST) state_n = SETTLE;
      RESULT:  state_n = last ? IDLE : WAIT_ENT;
      default: state_n = IDLE;
    endcase
    // Abort overrides any transition, including a measurement or result in the same cycle.
    if (abort && (state != IDLE)) begin
      state_n     = IDLE;
      load_result = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr         <= '0;
      pcnt        <= '0;
      target      <= '0;
      last        <= 1'b0;
      row_addr    <= '0;
      col_addr    <= '0;
      prog_mode   <= 1'b0;
      drain_en    <= 1'b0;
      res_ok      <= 1'b0;
      res_timeout <= 1'b0;
      res_pulses  <= '0;
    end else begin
      if ((state_n != state) || (state == IDLE) || (state == WAIT_ENT)) tmr <= '0;
      else                                                              tmr <= tmr + 1'b1;

      if (accept) begin
        row_addr  <= ent_row;
        col_addr  <= ent_col;
        target    <= ent_target;
        last      <= ent_last;
        pcnt      <= '0;
        prog_mode <= 1'b1;
        drain_en  <= 1'b1;
      end

      if ((state == INJECT) && (state_n == SETTLE) && (pcnt != PCNT_SAT)) pcnt <= pcnt + 1'b1;

      if (load_result) begin
        res_ok      <= result_ok;
        res_timeout <= result_timeout;
        res_pulses  <= pcnt;
        drain_en    <= 1'b0;
      end

      // prog_mode stays up between entries of a session and drops only after its last result.
      if ((state == RESULT) && (state_n == IDLE)) prog_mode <= 1'b0;

      if (abort && (state != IDLE)) begin
        prog_mode <= 1'b0;
        drain_en  <= 1'b0;
      end
    end
  end

endmodule
